axi4_stream_packet_source: RTL and testbench

//  Upstream AXI4-Stream master that feeds axi4_stream_ingress_demo (or any stream slave).
//  On a start pulse it emits N packets of L beats each. Each packet carries an incrementing

---
 rtl/axi4_stream_packet_source_pkg.sv | 19 +
 rtl/axi4_stream_packet_source.sv | 189 ++++++++++++++++++
 tb/tb_axi4_stream_packet_source.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_packet_source_pkg.sv
// ---------------------------------------------------------------------------
// axi4_stream_packet_source_pkg
// Shared AXI4-Stream side-band widths (also used by the ingress demo) and the
// state encoding of the packet source FSM.
// ---------------------------------------------------------------------------
package axi4_stream_packet_source_pkg;

    localparam int TID_WIDTH   = 4;
    localparam int TDEST_WIDTH = 32;
    localparam int TUSER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } src_state_e;

endpackage

// File: rtl/axi4_stream_packet_source.sv
// ---------------------------------------------------------------------------
// axi4_stream_packet_source
// AXI4-Stream master generating a run of i_packet_count packets of i_length
// beats each (length 0 is treated as 1). TDATA counts up from i_start_value
// across the whole run; TID/TDEST/TUSER are latched at the accepted start.
// Packets are separated by i_gap idle cycles. Every output is a register, so
// there is no combinational path from i_tready to the outputs.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_start               one-cycle start request (taken in IDLE only)
//   i_length              beats per packet
//   i_packet_count        packets per run (0 => start ignored)
//   i_gap                 idle cycles between packets
//   i_start_value         TDATA of the first beat of the run
//   i_tid/i_tdest/i_tuser side-band fields for the run
//   o_t*, i_tready        AXI4-Stream master interface
//   o_busy                run in progress
//   o_done                one-cycle pulse after the final handshake
//   o_packets_sent        saturating count of packets completed this run
// ---------------------------------------------------------------------------
module axi4_stream_packet_source
    import axi4_stream_packet_source_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [LEN_WIDTH-1:0]    i_length,
    input  logic [LEN_WIDTH-1:0]    i_packet_count,
    input  logic [LEN_WIDTH-1:0]    i_gap,
    input  logic [DATA_WIDTH-1:0]   i_start_value,
    input  logic [TID_WIDTH-1:0]    i_tid,
    input  logic [TDEST_WIDTH-1:0]  i_tdest,
    input  logic [TUSER_WIDTH-1:0]  i_tuser,
    output logic                    o_tvalid,
    output logic [DATA_WIDTH-1:0]   o_tdata,
    input  logic                    i_tready,
    output logic                    o_tlast,
    output logic [STROBE_WIDTH-1:0] o_tkeep,
    output logic [STROBE_WIDTH-1:0] o_tstrb,
    output logic [TID_WIDTH-1:0]    o_tid,
    output logic [TDEST_WIDTH-1:0]  o_tdest,
    output logic [TUSER_WIDTH-1:0]  o_tuser,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [LEN_WIDTH-1:0]    o_packets_sent
);

    localparam logic [LEN_WIDTH-1:0]    LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]    LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]    LEN_ONES  = {LEN_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]   DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STROBE_WIDTH-1:0] STRB_ONES = {STROBE_WIDTH{1'b1}};
    localparam logic [STROBE_WIDTH-1:0] STRB_ZERO = {STROBE_WIDTH{1'b0}};

    src_state_e               state_r;
    logic [LEN_WIDTH-1:0]     beat_cnt_r;   // beat index inside the current packet
    logic [LEN_WIDTH-1:0]     pkt_cnt_r;    // packets still to send, current one included
    logic [LEN_WIDTH-1:0]     gap_cnt_r;    // idle cycles still to spend in GAP
    logic [LEN_WIDTH-1:0]     len_r;        // effective length, never 0
    logic [LEN_WIDTH-1:0]     gap_r;
    logic [TID_WIDTH-1:0]     tid_r;
    logic [TDEST_WIDTH-1:0]   tdest_r;
    logic [TUSER_WIDTH-1:0]   tuser_r;

    // Packet source FSM with all stream and status outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            beat_cnt_r     <= LEN_ZERO;
            pkt_cnt_r      <= LEN_ZERO;
            gap_cnt_r      <= LEN_ZERO;
            len_r          <= LEN_ZERO;
            gap_r          <= LEN_ZERO;
            tid_r          <= {TID_WIDTH{1'b0}};
            tdest_r        <= {TDEST_WIDTH{1'b0}};
            tuser_r        <= {TUSER_WIDTH{1'b0}};
            o_tvalid       <= 1'b0;
            o_tdata        <= {DATA_WIDTH{1'b0}};
            o_tlast        <= 1'b0;
            o_tkeep        <= STRB_ZERO;
            o_tstrb        <= STRB_ZERO;
            o_tid          <= {TID_WIDTH{1'b0}};
            o_tdest        <= {TDEST_WIDTH{1'b0}};
            o_tuser        <= {TUSER_WIDTH{1'b0}};
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_packets_sent <= LEN_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start && (i_packet_count != LEN_ZERO)) begin
                        state_r        <= ST_SEND;
                        len_r          <= (i_length == LEN_ZERO) ? LEN_ONE : i_length;
                        gap_r          <= i_gap;
                        pkt_cnt_r      <= i_packet_count;
                        beat_cnt_r     <= LEN_ZERO;
                        tid_r          <= i_tid;
                        tdest_r        <= i_tdest;
                        tuser_r        <= i_tuser;
                        o_tvalid       <= 1'b1;
                        o_tdata        <= i_start_value;
                        o_tlast        <= (i_length <= LEN_ONE);
                        o_tkeep        <= STRB_ONES;
                        o_tstrb        <= STRB_ONES;
                        o_tid          <= i_tid;
                        o_tdest        <= i_tdest;
                        o_tuser        <= i_tuser;
                        o_busy         <= 1'b1;
                        o_packets_sent <= LEN_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (o_tvalid && i_tready) begin
                        o_tdata <= o_tdata + DATA_ONE;
                        if (o_tlast) begin
                            if (o_packets_sent != LEN_ONES) begin
                                o_packets_sent <= o_packets_sent + LEN_ONE;
                            end else begin
                                o_packets_sent <= o_packets_sent;
                            end
                            beat_cnt_r <= LEN_ZERO;
                            pkt_cnt_r  <= pkt_cnt_r - LEN_ONE;
                            if ((pkt_cnt_r == LEN_ONE) || (gap_r != LEN_ZERO)) begin
                                // Leaving SEND: drop the stream for GAP or DONE
                                o_tvalid <= 1'b0;
                                o_tlast  <= 1'b0;
                                o_tkeep  <= STRB_ZERO;
                                o_tstrb  <= STRB_ZERO;
                                o_tid    <= {TID_WIDTH{1'b0}};
                                o_tdest  <= {TDEST_WIDTH{1'b0}};
                                o_tuser  <= {TUSER_WIDTH{1'b0}};
                                if (pkt_cnt_r == LEN_ONE) begin
                                    state_r <= ST_DONE;
                                    o_busy  <= 1'b0;
                                    o_done  <= 1'b1;
                                end else begin
                                    state_r   <= ST_GAP;
                                    gap_cnt_r <= gap_r;
                                end
                            end else begin
                                // Back-to-back packet: first beat of the next one
                                o_tlast <= (len_r == LEN_ONE);
                            end
                        end else begin
                            beat_cnt_r <= beat_cnt_r + LEN_ONE;
                            o_tlast    <= ((beat_cnt_r + LEN_ONE) == (len_r - LEN_ONE));
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == LEN_ONE) begin
                        state_r  <= ST_SEND;
                        o_tvalid <= 1'b1;
                        o_tlast  <= (len_r == LEN_ONE);
                        o_tkeep  <= STRB_ONES;
                        o_tstrb  <= STRB_ONES;
                        o_tid    <= tid_r;
                        o_tdest  <= tdest_r;
                        o_tuser  <= tuser_r;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - LEN_ONE;
                    end
                end
                ST_DONE: begin
                    // Start requests here are deliberately dropped
                    state_r <= ST_IDLE;
                    o_done  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    o_tvalid <= 1'b0;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_stream_packet_source.sv
// ---------------------------------------------------------------------------
// tb_axi4_stream_packet_source
// Self-checking bench: an event-level model expands each accepted run into a
// queue of expected beats and tracks the idle gaps, done pulse and packet
// count; the DUT is compared to it on every falling edge. Directed tests pin
// the model with literal values; random runs use random TREADY.
// ---------------------------------------------------------------------------
module tb_axi4_stream_packet_source;
    import axi4_stream_packet_source_pkg::*;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_length = '0;
    logic [LW-1:0] i_packet_count = '0;
    logic [LW-1:0] i_gap = '0;
    logic [DW-1:0] i_start_value = '0;
    logic [3:0]    i_tid = '0;
    logic [31:0]   i_tdest = '0;
    logic [3:0]    i_tuser = '0;
    logic          i_tready = 1'b1;
    logic          o_tvalid, o_tlast, o_busy, o_done;
    logic [DW-1:0] o_tdata;
    logic [SW-1:0] o_tkeep, o_tstrb;
    logic [3:0]    o_tid, o_tuser;
    logic [31:0]   o_tdest;
    logic [LW-1:0] o_packets_sent;

    axi4_stream_packet_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_length(i_length),
        .i_packet_count(i_packet_count), .i_gap(i_gap), .i_start_value(i_start_value),
        .i_tid(i_tid), .i_tdest(i_tdest), .i_tuser(i_tuser),
        .o_tvalid(o_tvalid), .o_tdata(o_tdata), .i_tready(i_tready), .o_tlast(o_tlast),
        .o_tkeep(o_tkeep), .o_tstrb(o_tstrb), .o_tid(o_tid), .o_tdest(o_tdest),
        .o_tuser(o_tuser), .o_busy(o_busy), .o_done(o_done), .o_packets_sent(o_packets_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic          m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [LW-1:0] m_sent = '0;
    int            m_idle = 0, m_gap = 0;
    logic [3:0]    m_tid = '0, m_tuser = '0;
    logic [31:0]   m_tdest = '0;

    int            cyc = 0;
    int            done_cnt = 0, done_cyc = 0, hs_cnt = 0;
    logic [DW-1:0] hs_log[$];
    logic          rand_rdy = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    // TREADY: always ready, or random when rand_rdy is set
    always @(posedge clk) begin
        #2;
        i_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare DUT with model, then advance the model by one clock
    always @(negedge clk) begin : compare
        logic old_busy, old_done;
        int   eff;
        beat_t b, e;
        chk("tvalid", 64'(o_tvalid), 64'(m_valid));
        chk("busy", 64'(o_busy), 64'(m_busy));
        chk("done", 64'(o_done), 64'(m_done));
        chk("packets_sent", 64'(o_packets_sent), 64'(m_sent));
        if (m_valid && exp_q.size() > 0) begin
            chk("tdata", 64'(o_tdata), 64'(exp_q[0].data));
            chk("tlast", 64'(o_tlast), 64'(exp_q[0].last));
            chk("tkeep", 64'(o_tkeep), 64'({SW{1'b1}}));
            chk("tstrb", 64'(o_tstrb), 64'({SW{1'b1}}));
            chk("tid", 64'(o_tid), 64'(m_tid));
            chk("tdest", 64'(o_tdest), 64'(m_tdest));
            chk("tuser", 64'(o_tuser), 64'(m_tuser));
        end else begin
            chk("tkeep_idle", 64'(o_tkeep), 64'(0));
            chk("tside_idle", 64'({o_tid, o_tdest, o_tuser, o_tstrb}), 64'(0));
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_tvalid && i_tready) begin
            hs_cnt++;
            hs_log.push_back(o_tdata);
        end

        old_busy = m_busy;
        old_done = m_done;
        if (rst) begin
            exp_q.delete();
            m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_sent = '0;
            m_idle = 0; m_tid = '0; m_tdest = '0; m_tuser = '0;
        end else begin
            m_done = 1'b0;
            if (m_valid && i_tready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.last) begin
                    if (m_sent != {LW{1'b1}}) m_sent = m_sent + 1'b1;
                    if (exp_q.size() == 0) begin
                        m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                    end else if (m_gap > 0) begin
                        m_valid = 1'b0; m_idle = m_gap;
                    end
                end
            end else if (m_busy && !m_valid) begin
                m_idle--;
                if (m_idle <= 0) m_valid = 1'b1;
            end
            if (!old_busy && !old_done && i_start && i_packet_count != 0) begin
                eff = (i_length == 0) ? 1 : int'(i_length);
                for (int p = 0; p < int'(i_packet_count); p++) begin
                    for (int k = 0; k < eff; k++) begin
                        b.data = i_start_value + DW'(p * eff + k);
                        b.last = (k == eff - 1);
                        exp_q.push_back(b);
                    end
                end
                m_valid = 1'b1; m_busy = 1'b1; m_sent = '0;
                m_gap = int'(i_gap);
                m_tid = i_tid; m_tdest = i_tdest; m_tuser = i_tuser;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int start_cyc = 0;

    task automatic pulse_start(input int len, input int cnt, input int gap,
                               input logic [DW-1:0] sv);
        @(posedge clk); #2;
        i_length = LW'(len); i_packet_count = LW'(cnt); i_gap = LW'(gap);
        i_start_value = sv;
        i_tid = 4'($urandom); i_tdest = $urandom; i_tuser = 4'($urandom);
        i_start = 1'b1;
        @(posedge clk); #2;
        start_cyc = cyc;
        i_start = 1'b0;
        // Scramble the run inputs: they must have been latched already
        i_length = LW'($urandom); i_packet_count = LW'($urandom);
        i_gap = LW'($urandom); i_start_value = $urandom;
        i_tid = 4'($urandom); i_tdest = $urandom; i_tuser = 4'($urandom);
    endtask

    task automatic wait_done(input string name, input int bound);
        int c = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && c < bound) begin
            @(posedge clk); #2;
            c++;
        end
        if (done_cnt == d0) chk({name, "_timeout"}, 64'(0), 64'(1));
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0, h0;
        logic [DW-1:0] sv;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_tvalid", 64'(o_tvalid), 64'(0));
        chk("reset_tdata", 64'(o_tdata), 64'(0));
        chk("reset_sent", 64'(o_packets_sent), 64'(0));
        rst = 1'b0;
        idle(2);

        // 1: four beats from 0x10, done in the fifth cycle counting the start cycle
        hs_log.delete();
        pulse_start(4, 1, 0, 32'h10);
        wait_done("t1", 50);
        chk("t1_beats", 64'(hs_log.size()), 64'(4));
        if (hs_log.size() == 4) begin
            chk("t1_first", 64'(hs_log[0]), 64'h10);
            chk("t1_last", 64'(hs_log[3]), 64'h13);
        end
        chk("t1_done_lat", 64'(done_cyc - start_cyc), 64'(4));

        // 2: two packets of three with a two-cycle gap
        hs_log.delete();
        d0 = done_cnt;
        pulse_start(3, 2, 2, 32'h0);
        wait_done("t2", 50);
        chk("t2_beats", 64'(hs_log.size()), 64'(6));
        if (hs_log.size() == 6) chk("t2_beat5", 64'(hs_log[5]), 64'h5);
        chk("t2_sent", 64'(o_packets_sent), 64'(2));
        chk("t2_done_pulses", 64'(done_cnt - d0), 64'(1));

        // 3: eight beats under random backpressure
        rand_rdy = 1'b1;
        hs_log.delete();
        sv = $urandom;
        pulse_start(8, 1, 0, sv);
        wait_done("t3", 200);
        chk("t3_beats", 64'(hs_log.size()), 64'(8));
        for (int i = 0; i < hs_log.size(); i++) chk("t3_order", 64'(hs_log[i]), 64'(sv + DW'(i)));
        rand_rdy = 1'b0;

        // 4: data wrap and zero length
        hs_log.delete();
        pulse_start(4, 1, 0, 32'hFFFF_FFFE);
        wait_done("t4a", 50);
        chk("t4_beats", 64'(hs_log.size()), 64'(4));
        if (hs_log.size() == 4) begin
            chk("t4_b1", 64'(hs_log[1]), 64'hFFFF_FFFF);
            chk("t4_b2", 64'(hs_log[2]), 64'h0);
            chk("t4_b3", 64'(hs_log[3]), 64'h1);
        end
        hs_log.delete();
        pulse_start(0, 1, 0, 32'h55);
        wait_done("t4b", 50);
        chk("t4_len0_beats", 64'(hs_log.size()), 64'(1));

        // 5: start during a run and a zero-count start are both ignored
        h0 = hs_cnt;
        d0 = done_cnt;
        pulse_start(6, 2, 1, 32'h200);
        idle(3);
        @(posedge clk); #2;
        i_packet_count = 16'd3; i_length = 16'd2; i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        wait_done("t5", 100);
        chk("t5_beats", 64'(hs_cnt - h0), 64'(12));
        h0 = hs_cnt;
        @(posedge clk); #2;
        i_packet_count = 16'd0; i_length = 16'd4; i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        idle(10);
        chk("t5_no_beats", 64'(hs_cnt - h0), 64'(0));
        chk("t5_done_pulses", 64'(done_cnt - d0), 64'(1));

        // 6: reset in the middle of a packet, then a clean run
        h0 = hs_cnt;
        pulse_start(5, 1, 0, 32'h300);
        begin
            int c = 0;
            while (hs_cnt - h0 < 2 && c < 50) begin
                @(posedge clk); #2;
                c++;
            end
        end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("t6_tvalid_after_rst", 64'(o_tvalid), 64'(0));
        chk("t6_busy_after_rst", 64'(o_busy), 64'(0));
        idle(2);
        hs_log.delete();
        pulse_start(3, 1, 0, 32'h100);
        wait_done("t6", 50);
        chk("t6_beats", 64'(hs_log.size()), 64'(3));
        if (hs_log.size() == 3) chk("t6_b2", 64'(hs_log[2]), 64'h102);

        // Random runs with random backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 8; r++) begin
            pulse_start(int'($urandom_range(0, 6)), int'($urandom_range(1, 3)),
                        int'($urandom_range(0, 3)), $urandom);
            wait_done("rand", 400);
        end
        rand_rdy = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
